// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Contents: state encoding, default controller widths, counter-width helper.
package mem_arb_pkg;

    localparam int unsigned MEMORY_CONTROLLER_ADDR_SIZE = 32;
    localparam int unsigned MEMORY_CONTROLLER_DATA_SIZE = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational requester picker for the memory-port arbiter.
// Ports: req_i (request vector), last_owner_i (previous owner),
//        found_o (any request present), idx_o (selected index).
// Optional feature macro: ARB_FIXED_PRIO_EN selects lowest-index priority
// instead of round-robin starting after last_owner_i.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner_i;

    // Lowest requesting index wins.
    always_comb begin
        logic             hit;
        logic [IDX_W-1:0] sel;
        hit = 1'b0;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req_i[i]) begin
                hit = 1'b1;
                sel = IDX_W'(i);
            end
        end
        found_o = hit;
        idx_o   = sel;
    end
`else
    // Indices above last owner are searched first, then the wrap from index 0.
    always_comb begin
        logic             hit;
        logic [IDX_W-1:0] sel;
        hit = 1'b0;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req_i[i] && (IDX_W'(i) > last_owner_i)) begin
                hit = 1'b1;
                sel = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req_i[i] && (IDX_W'(i) <= last_owner_i)) begin
                hit = 1'b1;
                sel = IDX_W'(i);
            end
        end
        found_o = hit;
        idx_o   = sel;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory_controller port between NUM_REQ kernel FSMs.
// Round-robin ownership with a MAX_BURST cap, owner mux onto the controller,
// and one-cycle-later read-data return to the issuing requester.
// Ports: clk/reset (async, active-high); req/req_we/req_addr/req_wdata from
//        requesters; gnt/rvalid/rdata to requesters; memory_controller_*
//        to/from the controller.
// Optional feature macro: ARB_FIXED_PRIO_EN (lowest-index priority picker).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_W    = MEMORY_CONTROLLER_ADDR_SIZE,
    parameter int unsigned DATA_W    = MEMORY_CONTROLLER_DATA_SIZE,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         memory_controller_address,
    output logic                      memory_controller_write_enable,
    output logic [DATA_W-1:0]         memory_controller_in,
    input  logic [DATA_W-1:0]         memory_controller_out
);

    localparam int unsigned IDX_W = cnt_width(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]    rd_id_q, rd_id_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                access;

    mem_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .found_o      (pick_found),
        .idx_o        (pick_idx)
    );

    // An access happens in every granted cycle where the owner still requests.
    assign access = (state_q == ST_GRANT) && req[owner_q];

    // Next-state: arbitration in IDLE, burst accounting and release in GRANT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        gnt_d        = gnt_q;
        rd_pend_d    = 1'b0;
        rd_id_d      = rd_id_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d         = ST_GRANT;
                    owner_d         = pick_idx;
                    burst_cnt_d     = '0;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!access) begin
                    state_d      = ST_IDLE;
                    gnt_d        = '0;
                    last_owner_d = owner_q;
                end else begin
                    rd_pend_d = !req_we[owner_q];
                    rd_id_d   = owner_q;
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        gnt_d        = '0;
                        last_owner_d = owner_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and return-path registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            burst_cnt_q  <= '0;
            gnt_q        <= '0;
            rd_pend_q    <= 1'b0;
            rd_id_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            gnt_q        <= gnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_id_q      <= rd_id_d;
            if (rd_pend_q) begin
                rdata_q <= memory_controller_out;
            end
        end
    end

    // Owner mux onto the controller; idle or non-accessing cycles drive zero.
    always_comb begin
        memory_controller_address      = '0;
        memory_controller_write_enable = 1'b0;
        memory_controller_in           = '0;
        if (access) begin
            memory_controller_address      = req_addr[32'(owner_q)*ADDR_W +: ADDR_W];
            memory_controller_write_enable = req_we[owner_q];
            memory_controller_in           = req_wdata[32'(owner_q)*DATA_W +: DATA_W];
        end
    end

    // Read return: controller data passes through while valid, else held.
    always_comb begin
        rvalid = '0;
        if (rd_pend_q) begin
            rvalid[rd_id_q] = 1'b1;
        end
    end

    assign rdata = rd_pend_q ? memory_controller_out : rdata_q;
    assign gnt   = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a 32-entry synchronous RAM
// standing in for the memory controller and a transaction-level reference.
module tb_mem_port_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, req_we, gnt, rvalid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rdata, mc_in, mc_out;
    logic [AW-1:0]   mc_addr;
    logic            mc_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk                            (clk),
        .reset                          (reset),
        .req                            (req),
        .req_we                         (req_we),
        .req_addr                       (req_addr),
        .req_wdata                      (req_wdata),
        .gnt                            (gnt),
        .rvalid                         (rvalid),
        .rdata                          (rdata),
        .memory_controller_address      (mc_addr),
        .memory_controller_write_enable (mc_we),
        .memory_controller_in           (mc_in),
        .memory_controller_out          (mc_out)
    );

    // Controller stand-in: 32 words, one-cycle read latency, preloadable.
    logic [DW-1:0] ram [32];
    logic [DW-1:0] init_vals [32];
    logic          load_ram;

    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_vals[i];
        end else if (mc_we) begin
            ram[mc_addr[4:0]] <= mc_in;
        end
        mc_out <= ram[mc_addr[4:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: ownership as a count of accesses, memory as a shadow array.
    bit            m_busy;
    int            m_owner, m_cnt, m_last;
    bit            m_rv;
    int            m_rv_id;
    logic [DW-1:0] m_rv_data, m_hold;
    bit            m_hold_ok;
    logic [DW-1:0] shadow [32];

    task automatic model_reset();
        m_busy    = 0;
        m_owner   = 0;
        m_cnt     = 0;
        m_last    = N - 1;
        m_rv      = 0;
        m_hold_ok = 0;
    endtask

    // Advance the reference by one clock edge using the inputs held before it.
    task automatic model_edge();
        bit            acc, found;
        int            w, sel;
        logic [AW-1:0] a;
        if (m_rv) begin
            m_hold    = m_rv_data;
            m_hold_ok = 1;
        end
        m_rv = 0;
        if (m_busy) begin
            acc = req[m_owner];
            if (acc) begin
                a = req_addr[m_owner*AW +: AW];
                if (req_we[m_owner]) begin
                    shadow[a[4:0]] = req_wdata[m_owner*DW +: DW];
                end else begin
                    m_rv      = 1;
                    m_rv_id   = m_owner;
                    m_rv_data = shadow[a[4:0]];
                end
                m_cnt++;
            end
            if (!acc || m_cnt == MB) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end else begin
            found = 0;
            sel   = 0;
            for (int k = 0; k < N; k++) begin
`ifdef ARB_FIXED_PRIO_EN
                w = k;
`else
                w = (m_last + 1 + k) % N;
`endif
                if (!found && req[w]) begin
                    found = 1;
                    sel   = w;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_owner = sel;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [N-1:0]  eg, ev;
        bit            acc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        eg = '0;
        ev = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        if (m_rv) ev[m_rv_id] = 1'b1;
        acc = m_busy && req[m_owner];
        ea  = acc ? req_addr[m_owner*AW +: AW] : '0;
        ed  = acc ? req_wdata[m_owner*DW +: DW] : '0;
        check_eq("gnt", 64'(gnt), 64'(eg));
        check_eq("mc_we", 64'(mc_we), 64'(acc && req_we[m_owner]));
        check_eq("mc_addr", 64'(mc_addr), 64'(ea));
        check_eq("mc_in", 64'(mc_in), 64'(ed));
        check_eq("rvalid", 64'(rvalid), 64'(ev));
        if (m_rv) check_eq("rdata", 64'(rdata), 64'(m_rv_data));
        else if (m_hold_ok) check_eq("rdata_hold", 64'(rdata), 64'(m_hold));
    endtask

    // One clock: reference advances on the edge, new inputs go in, outputs checked.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        @(posedge clk);
        model_edge();
        #1;
        req       = r;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        compare_outputs();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop before any edge.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check_eq("rst_gnt", 64'(gnt), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_mc_we", 64'(mc_we), 64'd0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        compare_outputs();
    endtask

    function automatic logic [N*AW-1:0] av(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        return {a1, a0};
    endfunction

    function automatic logic [N*DW-1:0] dv(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        return {d1, d0};
    endfunction

    initial begin
        logic [N-1:0]    rr, rw;
        logic [N*AW-1:0] ra;
        logic [N*DW-1:0] rd;

        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            init_vals[i] = $urandom;
            shadow[i]    = init_vals[i];
        end
        load_ram = 1'b1;
        @(posedge clk);
        #1 load_ram = 1'b0;
        #1;
        check_eq("reset_gnt", 64'(gnt), 64'd0);
        check_eq("reset_rvalid", 64'(rvalid), 64'd0);
        check_eq("reset_mc_we", 64'(mc_we), 64'd0);
        check_eq("reset_mc_addr", 64'(mc_addr), 64'd0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        compare_outputs();

        // Single write of A5 to address 5, then read it back.
        step('0, '0, '0, '0);
        step(2'b01, 2'b01, av(32'd5, 32'd0), dv(32'h5A5A_00A5, 32'd0));
        step(2'b01, 2'b01, av(32'd5, 32'd0), dv(32'h5A5A_00A5, 32'd0));
        step(2'b00, 2'b00, '0, '0);
        step(2'b00, 2'b00, '0, '0);
        step(2'b01, 2'b00, av(32'd5, 32'd0), '0);
        step(2'b01, 2'b00, av(32'd5, 32'd0), '0);
        step(2'b00, 2'b00, '0, '0);
        check_eq("dir_rvalid0", 64'(rvalid), 64'd1);
        check_eq("dir_rdata_a5", 64'(rdata[7:0]), 64'hA5);
        step(2'b00, 2'b00, '0, '0);

        // Both requesting continuously: bursts of MB with idle gaps.
        for (int c = 0; c < 4 * (MB + 1) + 3; c++) begin
            step(2'b11, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        end
        step(2'b00, 2'b00, '0, '0);
        step(2'b00, 2'b00, '0, '0);

        // Sole requester held: re-granted after each forced release.
        for (int c = 0; c < 2 * (MB + 1) + 2; c++) begin
            step(2'b01, 2'b00, av(AW'($urandom), 32'd0), '0);
        end
        step(2'b00, 2'b00, '0, '0);
        step(2'b00, 2'b00, '0, '0);

        // Owner 1 reads 3 then 4 back-to-back, then drops req.
        step(2'b10, 2'b00, av(32'd0, 32'd3), '0);
        step(2'b10, 2'b00, av(32'd0, 32'd3), '0);
        step(2'b10, 2'b00, av(32'd0, 32'd4), '0);
        check_eq("dir_rd3_data", 64'(rdata), 64'(shadow[3]));
        step(2'b00, 2'b00, '0, '0);
        check_eq("dir_rd4_valid", 64'(rvalid), 64'h2);
        step(2'b00, 2'b00, '0, '0);

        // Request pulse that drops exactly as the grant rises.
        step(2'b01, 2'b01, av(32'd7, 32'd0), dv(32'h1234_5678, 32'd0));
        step(2'b00, 2'b01, av(32'd7, 32'd0), dv(32'h1234_5678, 32'd0));
        step(2'b00, 2'b00, '0, '0);
        step(2'b00, 2'b00, '0, '0);

        // Reset during a read burst from owner 1, then both request.
        step(2'b10, 2'b00, av(32'd0, 32'd9), '0);
        step(2'b10, 2'b00, av(32'd0, 32'd9), '0);
        step(2'b10, 2'b00, av(32'd0, 32'd10), '0);
        do_reset();
        step(2'b11, 2'b00, av(32'd1, 32'd2), '0);
        step(2'b11, 2'b00, av(32'd1, 32'd2), '0);
        step(2'b00, 2'b00, '0, '0);
        step(2'b00, 2'b00, '0, '0);

        // Random traffic: requests toggle occasionally so bursts vary in length.
        rr = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) rr[i] = ~rr[i];
            end
            rw = N'($urandom);
            ra = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            step(rr, rw, ra, rd);
            if ($urandom_range(299) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
